// File: rtl/csr_counter_unit_pkg.sv
// Shared types for the performance-counter CSR slice: CSR addresses,
// privilege levels and the counter-enable/inhibit bit layout.
package csr_counter_unit_pkg;

   typedef logic [11:0] csr_addr_t;

   typedef enum logic [1:0] {
      PrivUser       = 2'b00,
      PrivSupervisor = 2'b01,
      PrivMachine    = 2'b11
   } Privilege;

   // Bit 0 = CY, bit 1 = TM, bit 2 = IR, matching the architectural layout.
   typedef struct packed {
      logic ir;
      logic tm;
      logic cy;
   } csr_counteren_t;

   localparam csr_addr_t CsrMcycle        = 12'hB00;
   localparam csr_addr_t CsrMcycleh       = 12'hB80;
   localparam csr_addr_t CsrMinstret      = 12'hB02;
   localparam csr_addr_t CsrMinstreth     = 12'hB82;
   localparam csr_addr_t CsrCycle         = 12'hC00;
   localparam csr_addr_t CsrCycleh        = 12'hC80;
   localparam csr_addr_t CsrTime          = 12'hC01;
   localparam csr_addr_t CsrTimeh         = 12'hC81;
   localparam csr_addr_t CsrInstret       = 12'hC02;
   localparam csr_addr_t CsrInstreth      = 12'hC82;
   localparam csr_addr_t CsrMcounteren    = 12'h306;
   localparam csr_addr_t CsrScounteren    = 12'h106;
   localparam csr_addr_t CsrMcountinhibit = 12'h320;

   function automatic logic [31:0] counterenToWord(input csr_counteren_t r);
      return {29'b0, r};
   endfunction

endpackage

// File: rtl/csr_counter_unit_counter64.sv
// 64-bit counter with independent low/high word load ports.
// A low-word load suppresses the carry; a high-word load discards it.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        incEnable,
   input  logic        writeLow,
   input  logic        writeHigh,
   input  logic [31:0] writeData,
   output logic [63:0] count
);

   logic [31:0] lowReg;
   logic [31:0] highReg;
   logic [32:0] lowSum;
   logic [31:0] lowNext;
   logic [31:0] highNext;

   always_comb begin
      lowSum   = {1'b0, lowReg} + {32'b0, incEnable};
      lowNext  = lowSum[31:0];
      highNext = highReg + {31'b0, lowSum[32]};
      // Any write to a half overrides its own increment and kills the carry path.
      if (writeLow) begin
         lowNext  = writeData;
         highNext = highReg;
      end
      if (writeHigh) begin
         highNext = writeData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lowReg  <= '0;
         highReg <= '0;
      end else begin
         lowReg  <= lowNext;
         highReg <= highNext;
      end
   end

   assign count = {highReg, lowReg};

endmodule

// File: rtl/csr_counter_unit.sv
// RV32 performance counters (mcycle, minstret, time) plus mcounteren,
// scounteren and mcountinhibit, with the execute-side access check.
module csr_counter_unit
   import csr_counter_unit_pkg::*;
#(
   parameter int TimeDivider = 1
) (
   input  logic      clk,
   input  logic      rst,
   input  csr_addr_t readAddr,
   input  logic      readEnable,
   input  logic      accessWrite,
   input  Privilege  privilege,
   input  csr_addr_t writeAddr,
   input  logic [31:0] writeValue,
   input  logic      writeEnable,
   input  logic      retire,
   output logic      hit,
   output logic [31:0] readValue,
   output logic      readIllegal
);

   localparam logic [7:0] PrescaleLast = 8'(TimeDivider - 1);

   csr_counteren_t mcounteren;
   csr_counteren_t scounteren;
   csr_counteren_t mcountinhibit;
   logic [7:0]     prescaler;
   logic           timeTick;

   logic [63:0] cycleCount;
   logic [63:0] instretCount;
   logic [63:0] timeCount;

   logic wrMcycleLo, wrMcycleHi, wrMinstretLo, wrMinstretHi;
   logic instretInc;

   assign wrMcycleLo   = writeEnable && (writeAddr == CsrMcycle);
   assign wrMcycleHi   = writeEnable && (writeAddr == CsrMcycleh);
   assign wrMinstretLo = writeEnable && (writeAddr == CsrMinstret);
   assign wrMinstretHi = writeEnable && (writeAddr == CsrMinstreth);

   // The instruction that writes minstret is not itself counted.
   assign instretInc = retire && !mcountinhibit.ir && !wrMinstretLo && !wrMinstretHi;

   assign timeTick = (prescaler == PrescaleLast);

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler <= '0;
      end else if (timeTick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcounteren    <= '0;
         scounteren    <= '0;
         mcountinhibit <= '0;
      end else if (writeEnable) begin
         case (writeAddr)
            CsrMcounteren:    mcounteren <= writeValue[2:0];
            CsrScounteren:    scounteren <= writeValue[2:0];
            CsrMcountinhibit: mcountinhibit <= '{ir: writeValue[2], tm: 1'b0, cy: writeValue[0]};
            default: ;
         endcase
      end
   end

   csr_counter64 cycleCounter (
      .clk       (clk),
      .rst       (rst),
      .incEnable (!mcountinhibit.cy),
      .writeLow  (wrMcycleLo),
      .writeHigh (wrMcycleHi),
      .writeData (writeValue),
      .count     (cycleCount)
   );

   csr_counter64 instretCounter (
      .clk       (clk),
      .rst       (rst),
      .incEnable (instretInc),
      .writeLow  (wrMinstretLo),
      .writeHigh (wrMinstretHi),
      .writeData (writeValue),
      .count     (instretCount)
   );

   csr_counter64 timeCounter (
      .clk       (clk),
      .rst       (rst),
      .incEnable (timeTick),
      .writeLow  (1'b0),
      .writeHigh (1'b0),
      .writeData (writeValue),
      .count     (timeCount)
   );

   always_comb begin
      hit       = 1'b1;
      readValue = '0;
      case (readAddr)
         CsrMcycle,   CsrCycle:     readValue = cycleCount[31:0];
         CsrMcycleh,  CsrCycleh:    readValue = cycleCount[63:32];
         CsrMinstret, CsrInstret:   readValue = instretCount[31:0];
         CsrMinstreth, CsrInstreth: readValue = instretCount[63:32];
         CsrTime:                   readValue = timeCount[31:0];
         CsrTimeh:                  readValue = timeCount[63:32];
         CsrMcounteren:             readValue = counterenToWord(mcounteren);
         CsrScounteren:             readValue = counterenToWord(scounteren);
         CsrMcountinhibit:          readValue = counterenToWord(mcountinhibit);
         default:                   hit = 1'b0;
      endcase
   end

   logic [3:0] mEnVec;
   logic [3:0] sEnVec;
   logic [1:0] counterIdx;

   assign mEnVec     = {1'b0, mcounteren};
   assign sEnVec     = {1'b0, scounteren};
   assign counterIdx = readAddr[1:0];

   // addr[9:8] encodes the lowest privilege allowed; addr[11:10]==11 marks read-only.
   always_comb begin
      readIllegal = 1'b0;
      if (readEnable && hit) begin
         if (privilege < readAddr[9:8]) begin
            readIllegal = 1'b1;
         end else if (readAddr[11:10] == 2'b11) begin
            if (accessWrite) begin
               readIllegal = 1'b1;
            end else begin
               case (privilege)
                  PrivSupervisor: readIllegal = !mEnVec[counterIdx];
                  PrivUser:       readIllegal = !(mEnVec[counterIdx] && sEnVec[counterIdx]);
                  default:        readIllegal = 1'b0;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit: counter timing, write/carry rules,
// inhibit behaviour and the privilege access check.
module tb_csr_counter_unit;
   import csr_counter_unit_pkg::*;

   localparam int TimeDiv = 4;

   logic        clk;
   logic        rst;
   csr_addr_t   readAddr;
   logic        readEnable;
   logic        accessWrite;
   Privilege    privilege;
   csr_addr_t   writeAddr;
   logic [31:0] writeValue;
   logic        writeEnable;
   logic        retire;
   logic        hit;
   logic [31:0] readValue;
   logic        readIllegal;

   int total = 0;
   int bad   = 0;
   int edgesLive = 0;

   typedef struct {
      logic [11:0] addr;
      logic        en;
      logic        aw;
      Privilege    priv;
      logic        expHit;
      logic        expIll;
      logic        chkVal;
      logic [31:0] expVal;
   } AccessVec;

   AccessVec vecs[16];

   csr_counter_unit #(.TimeDivider(TimeDiv)) dut (
      .clk         (clk),
      .rst         (rst),
      .readAddr    (readAddr),
      .readEnable  (readEnable),
      .accessWrite (accessWrite),
      .privilege   (privilege),
      .writeAddr   (writeAddr),
      .writeValue  (writeValue),
      .writeEnable (writeEnable),
      .retire      (retire),
      .hit         (hit),
      .readValue   (readValue),
      .readIllegal (readIllegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         if (!rst) edgesLive++;
      end
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic readCheck(input string name, input logic [11:0] addr, input logic [31:0] exp);
      readAddr    = addr;
      readEnable  = 1'b1;
      accessWrite = 1'b0;
      privilege   = PrivMachine;
      #1;
      check(name, readValue, exp);
   endtask

   task automatic csrWrite(input logic [11:0] addr, input logic [31:0] val);
      writeEnable = 1'b1;
      writeAddr   = addr;
      writeValue  = val;
      step(1);
      writeEnable = 1'b0;
   endtask

   task automatic illCheck(input string name, input logic [11:0] addr, input Privilege p, input logic exp);
      readAddr    = addr;
      readEnable  = 1'b1;
      accessWrite = 1'b0;
      privilege   = p;
      #1;
      check(name, {31'b0, readIllegal}, {31'b0, exp});
   endtask

   initial begin
      vecs[0]  = '{12'hC00, 1'b1, 1'b0, PrivUser,       1'b1, 1'b1, 1'b0, 32'h0};
      vecs[1]  = '{12'hC00, 1'b1, 1'b0, PrivSupervisor, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{12'hC00, 1'b1, 1'b0, PrivMachine,    1'b1, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{12'hC01, 1'b1, 1'b0, PrivSupervisor, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[4]  = '{12'h320, 1'b1, 1'b0, PrivSupervisor, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[5]  = '{12'h320, 1'b1, 1'b0, PrivMachine,    1'b1, 1'b0, 1'b1, 32'h0};
      vecs[6]  = '{12'h106, 1'b1, 1'b0, PrivSupervisor, 1'b1, 1'b0, 1'b1, 32'h0};
      vecs[7]  = '{12'h106, 1'b1, 1'b0, PrivUser,       1'b1, 1'b1, 1'b0, 32'h0};
      vecs[8]  = '{12'hB00, 1'b1, 1'b0, PrivSupervisor, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{12'hC02, 1'b1, 1'b1, PrivMachine,    1'b1, 1'b1, 1'b0, 32'h0};
      vecs[10] = '{12'h300, 1'b1, 1'b0, PrivMachine,    1'b0, 1'b0, 1'b1, 32'h0};
      vecs[11] = '{12'h300, 1'b1, 1'b1, PrivUser,       1'b0, 1'b0, 1'b1, 32'h0};
      vecs[12] = '{12'hC00, 1'b0, 1'b0, PrivUser,       1'b1, 1'b0, 1'b0, 32'h0};
      vecs[13] = '{12'h306, 1'b1, 1'b0, PrivMachine,    1'b1, 1'b0, 1'b1, 32'h1};
      vecs[14] = '{12'hC81, 1'b1, 1'b0, PrivMachine,    1'b1, 1'b0, 1'b0, 32'h0};
      vecs[15] = '{12'hB82, 1'b1, 1'b1, PrivMachine,    1'b1, 1'b0, 1'b0, 32'h0};

      rst         = 1'b1;
      readAddr    = '0;
      readEnable  = 1'b0;
      accessWrite = 1'b0;
      privilege   = PrivMachine;
      writeAddr   = '0;
      writeValue  = '0;
      writeEnable = 1'b0;
      retire      = 1'b0;
      step(3);

      // Reset state
      readCheck("rst_mcycle", 12'hB00, 32'h0);
      readCheck("rst_time", 12'hC01, 32'h0);
      readCheck("rst_mcounteren", 12'h306, 32'h0);
      illCheck("rst_u_cycle_ill", 12'hC00, PrivUser, 1'b1);

      rst = 1'b0;
      step(10);
      readCheck("idle_mcycle", 12'hB00, 32'd10);
      readCheck("idle_mcycleh", 12'hB80, 32'd0);
      readCheck("idle_time", 12'hC01, 32'd2);
      readCheck("idle_minstret", 12'hB02, 32'd0);

      // Low-half load then natural carry into the high half
      csrWrite(12'hB00, 32'hFFFF_FFFF);
      readCheck("lo_load", 12'hB00, 32'hFFFF_FFFF);
      readCheck("lo_load_no_carry", 12'hB80, 32'd0);
      step(1);
      readCheck("carry_hi", 12'hB80, 32'd1);
      readCheck("carry_lo", 12'hB00, 32'd0);

      // High-half write on the wrap cycle discards the carry
      csrWrite(12'hB00, 32'hFFFF_FFFF);
      csrWrite(12'hB80, 32'd5);
      readCheck("hi_write_wins", 12'hB80, 32'd5);
      readCheck("hi_write_lo_wrap", 12'hB00, 32'd0);
      step(1);
      readCheck("after_hi_lo", 12'hB00, 32'd1);
      readCheck("cycle_alias_hi", 12'hC80, 32'd5);

      // minstret write with a same-cycle retire
      writeEnable = 1'b1;
      writeAddr   = 12'hB02;
      writeValue  = 32'd100;
      retire      = 1'b1;
      step(1);
      writeEnable = 1'b0;
      readCheck("minstret_write", 12'hB02, 32'd100);
      step(1);
      retire = 1'b0;
      readCheck("minstret_retire", 12'hB02, 32'd101);
      readCheck("instret_alias", 12'hC02, 32'd101);

      // Inhibit CY and IR; TM bit stays 0
      csrWrite(12'h320, 32'hFFFF_FFFF);
      readCheck("inhibit_readback", 12'h320, 32'h5);
      retire = 1'b1;
      step(20);
      retire = 1'b0;
      readCheck("inhibit_mcycle", 12'hB00, 32'd4);
      readCheck("inhibit_minstret", 12'hB02, 32'd101);
      readCheck("inhibit_time", 12'hC01, 32'(edgesLive / TimeDiv));
      csrWrite(12'h320, 32'h0);
      readCheck("uninhibit_edge", 12'hB00, 32'd4);
      step(1);
      readCheck("uninhibit_count", 12'hB00, 32'd5);

      // Commit writes to user aliases are dropped
      csrWrite(12'hC00, 32'h0);
      readCheck("alias_write_ignored", 12'hB00, 32'd6);
      readCheck("alias_write_hi", 12'hB80, 32'd5);

      // Access check table with mcounteren=CY only, scounteren=0
      csrWrite(12'h306, 32'hFFFF_FFF9);
      for (int i = 0; i < 16; i++) begin
         readAddr    = vecs[i].addr;
         readEnable  = vecs[i].en;
         accessWrite = vecs[i].aw;
         privilege   = vecs[i].priv;
         #1;
         check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].expHit});
         check($sformatf("vec%0d_ill", i), {31'b0, readIllegal}, {31'b0, vecs[i].expIll});
         if (vecs[i].chkVal) begin
            check($sformatf("vec%0d_val", i), readValue, vecs[i].expVal);
         end
      end

      csrWrite(12'h106, 32'h1);
      illCheck("u_cycle_scnt", 12'hC00, PrivUser, 1'b0);
      illCheck("u_time_scnt", 12'hC01, PrivUser, 1'b1);
      illCheck("u_instret_scnt", 12'hC02, PrivUser, 1'b1);
      readCheck("scounteren_read", 12'h106, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
